mult_adder_acc: RTL and testbench
=================================

# mult_adder_acc

Parametrised, fully pipelined signed/unsigned dot-product engine with a multi-beat accumulator. Each valid beat multiplies MA_TREE_SIZE data/kernel pairs, reduces the products through a registered adder tree, and accumulates the beat sums of a group delimited by first/last into one saturated result. It sits in the convolution datapath in place of the fixed 8-bit multiply-adder, so kernels larger than the tree can be processed over several beats.

## Interface
- MA_TREE_SIZE, 9, number of multiplier lanes (>= 1; need not be a power of two)
- DATA_WIDTH, 8, width of each data and kernel element
- ACC_WIDTH, 32, accumulator/result width; must be >= 2*DATA_WIDTH + clog2(MA_TREE_SIZE) (elaboration error otherwise)
- SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned
- clock  in  1  sole clock; all state on its rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  beat qualifier
- first  in  1  beat starts a new accumulation group (sampled only with in_valid)
- last  in  1  beat ends the group (sampled only with in_valid)
- in  in  DATA_WIDTH*MA_TREE_SIZE  data elements, lane i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
- kernel  in  DATA_WIDTH*MA_TREE_SIZE  kernel elements, same packing
- out_valid  out  1  one-cycle pulse: out/overflow hold a completed group result
- out  out  ACC_WIDTH  group sum, saturated
- overflow  out  1  group saturated at least once

## Operation
- Stage M: per-lane product, 2*DATA_WIDTH bits, signed or unsigned per SIGNED; registered.
- Tree: TREE_LVLS = clog2(MA_TREE_SIZE) registered pairwise-add levels (0 when size 1). Odd operand at a level passes through a register unchanged. Operands sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH before the first add; tree never overflows by parameter rule.
- Sideband (valid, first, last) travels in a shift register aligned with the data; invalid beats carry no effect.
- Stage A (accumulator), on an aligned valid beat:
  - first=1: acc <= beat_sum; sticky ovf <= 0.
  - first=0: acc <= sat(acc + beat_sum); ovf <= ovf | saturated.
  - last=1: out <= new acc value, overflow <= new ovf value, out_valid <= 1.
- first=1 and last=1 on one beat: single-beat group, result = beat_sum, overflow 0.
- Saturation: SIGNED=1 clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; SIGNED=0 clamps to 2^ACC_WIDTH-1. Addition computed at ACC_WIDTH+1 bits.
- Beat with first=0 after reset or after a last accumulates onto the current acc (0 after reset; the completed sum after a last). Software must assert first to begin a clean group.
- in_valid gaps inside a group are allowed; acc holds across idle cycles.
- out/overflow hold their value until the next out_valid; out_valid is high for exactly one cycle per last beat.

## Timing
- Throughput: one beat per cycle, no backpressure, no stalls.
- Latency: beat with last accepted at cycle T -> out_valid at T + TREE_LVLS + 2 (MA_TREE_SIZE=9: 6 cycles; 4: 4 cycles; 1: 2 cycles).
- Reset (reset=0 at an edge): all pipeline registers, sideband valids, acc, ovf, out, overflow, out_valid <= 0. In-flight beats discarded; no out_valid for any group straddling reset. Inputs ignored while reset=0.
- Back-to-back groups (last at cycle T, first at T+1) produce out_valid at consecutive cycles with independent results.

## Test plan
- SIGNED=1, size 4, DW 8, ACC 32: one beat first=last=1, in all 1, kernel all 2 -> out_valid at T+4, out=8, overflow=0.
- Signed extremes: in all -128, kernel all -128 (size 4) -> out=65536; in all -128, kernel all 127 -> out=-65024.
- Three-beat group with a 2-cycle in_valid gap mid-group, each beat sum 8 -> single out_valid 4 cycles after last, out=24; no pulses for non-last beats.
- ACC_WIDTH=18, size 4, signed: two beats of sum 65536 -> out=131071, overflow=1; next group single beat sum 5 -> out=5, overflow=0.
- Back-to-back single-beat groups every cycle with sums 1,2,3,4 -> four consecutive out_valid pulses with out 1,2,3,4; size 9 variant checks 6-cycle latency and odd-lane padding (lane 8 only nonzero: in=3, kernel=-4 -> out=-12).
- Reset mid-group: two beats in flight, reset low one cycle -> outputs all 0 next cycle, no out_valid from discarded beats; subsequent first=last beat sum 7 -> out=7.

Source files
------------

// File: rtl/mult_adder_acc.sv
// mult_adder_acc: pipelined dot-product engine. Per-lane multipliers feed a
// registered adder tree. A saturating accumulator then sums the beat results of
// each first..last group into one result.
module mult_adder_acc #(
  parameter int unsigned MA_TREE_SIZE = 9,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter bit          SIGNED       = 1'b1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic                               first,
  input  logic                               last,
  input  logic [DATA_WIDTH*MA_TREE_SIZE-1:0] in,
  input  logic [DATA_WIDTH*MA_TREE_SIZE-1:0] kernel,
  output logic                               out_valid,
  output logic [ACC_WIDTH-1:0]               out,
  output logic                               overflow
);

  localparam int unsigned TREE_LVLS = $clog2(MA_TREE_SIZE);
  localparam int unsigned PROD_W    = 2 * DATA_WIDTH;
  localparam int unsigned LEAVES    = 1 << TREE_LVLS;
  localparam int unsigned SUM_W     = ACC_WIDTH + 1;

  // Reject configurations where the tree or the lane count is unusable
  if (MA_TREE_SIZE < 1) begin : g_bad_size
    $error("MA_TREE_SIZE must be at least 1");
  end
  if (ACC_WIDTH < PROD_W + TREE_LVLS) begin : g_bad_acc
    $error("ACC_WIDTH too narrow for the product tree");
  end

  // ---------------- multiply stage ----------------
  logic [PROD_W-1:0] prod_d [MA_TREE_SIZE];
  logic [PROD_W-1:0] prod_q [MA_TREE_SIZE];

  // Per-lane product, sign handling chosen by SIGNED
  always_comb begin
    logic [DATA_WIDTH-1:0] lane_a;
    logic [DATA_WIDTH-1:0] lane_b;
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < int'(MA_TREE_SIZE); i++) begin
      lane_a = in[DATA_WIDTH*i +: DATA_WIDTH];
      lane_b = kernel[DATA_WIDTH*i +: DATA_WIDTH];
      if (SIGNED) begin
        prod_d[i] = PROD_W'($signed(lane_a)) * PROD_W'($signed(lane_b));
      end else begin
        prod_d[i] = PROD_W'(lane_a) * PROD_W'(lane_b);
      end
    end
  end

  // Product registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      prod_q <= '{default: '0};
    end else begin
      prod_q <= prod_d;
    end
  end

  // ---------------- adder tree ----------------
  // Leaves padded to a power of two with zeros; a zero partner makes an odd
  // operand pass through its level unchanged.
  logic [ACC_WIDTH-1:0] leaf [LEAVES];

  // Extend products to accumulator width
  always_comb begin
    leaf = '{default: '0};
    for (int j = 0; j < int'(MA_TREE_SIZE); j++) begin
      if (SIGNED) begin
        leaf[j] = ACC_WIDTH'($signed(prod_q[j]));
      end else begin
        leaf[j] = ACC_WIDTH'(prod_q[j]);
      end
    end
  end

  logic [ACC_WIDTH-1:0] beat_sum;

  if (TREE_LVLS == 0) begin : g_no_tree
    assign beat_sum = leaf[0];
  end else begin : g_tree
    // Heap layout: nodes 0..NODES-1 are registered sums, the rest are leaves;
    // every heap depth is one register stage.
    localparam int unsigned NODES = LEAVES - 1;
    logic [ACC_WIDTH-1:0] node_d [NODES];
    logic [ACC_WIDTH-1:0] node_q [NODES];
    logic [ACC_WIDTH-1:0] heap   [2*LEAVES-1];

    // Gather registered nodes and leaves into one indexable heap
    always_comb begin
      for (int k = 0; k < int'(NODES); k++) begin
        heap[k] = node_q[k];
      end
      for (int j = 0; j < int'(LEAVES); j++) begin
        heap[int'(NODES) + j] = leaf[j];
      end
    end

    // Pairwise sums of each node's two children
    always_comb begin
      for (int k = 0; k < int'(NODES); k++) begin
        node_d[k] = heap[2*k+1] + heap[2*k+2];
      end
    end

    // Tree level registers
    always_ff @(posedge clock) begin
      if (!reset) begin
        node_q <= '{default: '0};
      end else begin
        node_q <= node_d;
      end
    end

    assign beat_sum = node_q[0];
  end

  // ---------------- sideband alignment ----------------
  // {valid, first, last}, one entry per pipeline stage before the accumulator
  logic [2:0] sb_d [TREE_LVLS+1];
  logic [2:0] sb_q [TREE_LVLS+1];

  // Qualify first/last with valid and shift along with the data
  always_comb begin
    sb_d[0] = {in_valid, in_valid & first, in_valid & last};
    for (int k = 1; k <= int'(TREE_LVLS); k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  // Sideband registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      sb_q <= '{default: '0};
    end else begin
      sb_q <= sb_d;
    end
  end

  // ---------------- accumulator ----------------
  logic [ACC_WIDTH-1:0] acc_d, acc_q, out_d, out_q;
  logic                 ovf_d, ovf_q, overflow_d, overflow_q;
  logic                 out_valid_d, out_valid_q;
  logic [SUM_W-1:0]     sum_w;
  logic [ACC_WIDTH-1:0] sat_sum;
  logic                 sat_hit;
  logic                 beat_v, beat_f, beat_l;

  assign {beat_v, beat_f, beat_l} = sb_q[TREE_LVLS];

  // Saturating add of the beat sum onto the running group total
  always_comb begin
    if (SIGNED) begin
      sum_w   = SUM_W'($signed(acc_q)) + SUM_W'($signed(beat_sum));
      sat_hit = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
      sat_sum = sum_w[ACC_WIDTH-1:0];
      if (sat_hit) begin
        sat_sum = sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      sum_w   = SUM_W'(acc_q) + SUM_W'(beat_sum);
      sat_hit = sum_w[ACC_WIDTH];
      sat_sum = sat_hit ? {ACC_WIDTH{1'b1}} : sum_w[ACC_WIDTH-1:0];
    end
  end

  // Group bookkeeping: restart on first, publish on last
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_d       = out_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (beat_v) begin
      if (beat_f) begin
        acc_d = beat_sum;
        ovf_d = 1'b0;
      end else begin
        acc_d = sat_sum;
        ovf_d = ovf_q | sat_hit;
      end
      if (beat_l) begin
        out_d       = acc_d;
        overflow_d  = ovf_d;
        out_valid_d = 1'b1;
      end
    end
  end

  // Accumulator and result registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_q       <= out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mult_adder_acc.sv
// Self-checking bench for mult_adder_acc: four configurations share one clock,
// reset and beat control; each gets its own data buses.
module tb_mult_adder_acc;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, first_i, last_i;

  logic [31:0] s4_in, s4_k, a18_in, a18_k;
  logic [71:0] s9_in, s9_k;
  logic [7:0]  u1_in, u1_k;

  logic        s4_ov, s4_ovf, a18_ov, a18_ovf, s9_ov, s9_ovf, u1_ov, u1_ovf;
  logic [31:0] s4_out, s9_out;
  logic [17:0] a18_out;
  logic [15:0] u1_out;

  always #5 clk = ~clk;

  mult_adder_acc #(.MA_TREE_SIZE(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1)) u_s4 (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .first(first_i), .last(last_i),
    .in(s4_in), .kernel(s4_k), .out_valid(s4_ov), .out(s4_out), .overflow(s4_ovf));

  mult_adder_acc #(.MA_TREE_SIZE(4), .DATA_WIDTH(8), .ACC_WIDTH(18), .SIGNED(1)) u_a18 (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .first(first_i), .last(last_i),
    .in(a18_in), .kernel(a18_k), .out_valid(a18_ov), .out(a18_out), .overflow(a18_ovf));

  mult_adder_acc #(.MA_TREE_SIZE(9), .DATA_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1)) u_s9 (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .first(first_i), .last(last_i),
    .in(s9_in), .kernel(s9_k), .out_valid(s9_ov), .out(s9_out), .overflow(s9_ovf));

  mult_adder_acc #(.MA_TREE_SIZE(1), .DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0)) u_u1 (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .first(first_i), .last(last_i),
    .in(u1_in), .kernel(u1_k), .out_valid(u1_ov), .out(u1_out), .overflow(u1_ovf));

  typedef struct {
    int unsigned cyc;
    logic [31:0] out;
    logic        ovf;
  } ev_t;

  typedef struct {
    logic [31:0] din;
    logic [31:0] kin;
    logic [31:0] exp;
  } vec_t;

  ev_t q4[$], q18[$], q9[$], q1[$];
  int unsigned cyc = 0;
  int nchk = 0;
  int nerr = 0;

  // Edge counter: after edge N it reads N
  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse with the edge count it followed
  always @(negedge clk) begin
    if (s4_ov)  q4.push_back('{cyc: cyc, out: s4_out, ovf: s4_ovf});
    if (a18_ov) q18.push_back('{cyc: cyc, out: 32'(a18_out), ovf: a18_ovf});
    if (s9_ov)  q9.push_back('{cyc: cyc, out: s9_out, ovf: s9_ovf});
    if (u1_ov)  q1.push_back('{cyc: cyc, out: 32'(u1_out), ovf: u1_ovf});
  end

  function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_ev(input string nm, input ev_t q[$], input int idx,
                        input int unsigned ecyc, input logic [31:0] eout, input logic eovf);
    if (idx >= q.size()) begin
      nchk++;
      nerr++;
      $display("FAIL %s: result pulse %0d missing (got %0d pulses)", nm, idx, q.size());
    end else begin
      chk({nm, "_cycle"}, q[idx].cyc, ecyc);
      chk({nm, "_out"}, q[idx].out, eout);
      chk({nm, "_ovf"}, 32'(q[idx].ovf), 32'(eovf));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    first_i  = 1'b0;
    last_i   = 1'b0;
    repeat (n) step();
  endtask

  // Present one beat; e is the edge count at which it was accepted
  task automatic beat(input logic f, input logic l, output int unsigned e);
    in_valid = 1'b1;
    first_i  = f;
    last_i   = l;
    step();
    e = cyc;
    in_valid = 1'b0;
    first_i  = 1'b0;
    last_i   = 1'b0;
  endtask

  task automatic clr();
    q4.delete();
    q18.delete();
    q9.delete();
    q1.delete();
  endtask

  vec_t vecs[6];
  int unsigned e, e0;

  initial begin
    vecs[0] = '{din: p4(1, 1, 1, 1),         kin: p4(2, 2, 2, 2),         exp: 32'd8};
    vecs[1] = '{din: p4(-128, -128, -128, -128), kin: p4(-128, -128, -128, -128), exp: 32'd65536};
    vecs[2] = '{din: p4(-128, -128, -128, -128), kin: p4(127, 127, 127, 127),     exp: 32'(-65024)};
    vecs[3] = '{din: p4(1, -2, 3, -4),       kin: p4(5, 6, -7, 8),        exp: 32'(-60)};
    vecs[4] = '{din: p4(127, 127, 127, 127), kin: p4(127, 127, 127, 127), exp: 32'd64516};
    vecs[5] = '{din: p4(0, 0, 0, 0),         kin: p4(9, 9, 9, 9),         exp: 32'd0};

    rst_n = 1'b0;
    in_valid = 1'b0; first_i = 1'b0; last_i = 1'b0;
    s4_in = '0; s4_k = '0; a18_in = '0; a18_k = '0;
    s9_in = '0; s9_k = '0; u1_in = '0; u1_k = '0;
    repeat (3) step();
    chk("rst_out_valid", 32'(s4_ov), 32'd0);
    chk("rst_out", s4_out, 32'd0);
    chk("rst_overflow", 32'(s4_ovf), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Single-beat groups, size 4 signed
    for (int i = 0; i < 6; i++) begin
      clr();
      s4_in = vecs[i].din;
      s4_k  = vecs[i].kin;
      beat(1'b1, 1'b1, e);
      idle(6);
      chk($sformatf("vec%0d_pulses", i), q4.size(), 32'd1);
      chk_ev($sformatf("vec%0d", i), q4, 0, e + 3, vecs[i].exp, 1'b0);
    end

    // Three-beat group with a two-cycle gap
    clr();
    s4_in = p4(1, 1, 1, 1);
    s4_k  = p4(2, 2, 2, 2);
    beat(1'b1, 1'b0, e);
    idle(2);
    beat(1'b0, 1'b0, e);
    beat(1'b0, 1'b1, e);
    idle(6);
    chk("gap_pulses", q4.size(), 32'd1);
    chk_ev("gap", q4, 0, e + 3, 32'd24, 1'b0);

    // Positive saturation at 18 bits, then a clean group
    clr();
    a18_in = p4(-128, -128, -128, -128);
    a18_k  = p4(-128, -128, -128, -128);
    beat(1'b1, 1'b0, e);
    beat(1'b0, 1'b1, e);
    idle(6);
    chk("sat_pos_pulses", q18.size(), 32'd1);
    chk_ev("sat_pos", q18, 0, e + 3, 32'h1FFFF, 1'b1);
    clr();
    a18_in = p4(5, 0, 0, 0);
    a18_k  = p4(1, 0, 0, 0);
    beat(1'b1, 1'b1, e);
    idle(6);
    chk_ev("sat_clear", q18, 0, e + 3, 32'd5, 1'b0);

    // Negative saturation at 18 bits: 3 x -65024 < -131072
    clr();
    a18_in = p4(-128, -128, -128, -128);
    a18_k  = p4(127, 127, 127, 127);
    beat(1'b1, 1'b0, e);
    beat(1'b0, 1'b0, e);
    beat(1'b0, 1'b1, e);
    idle(6);
    chk_ev("sat_neg", q18, 0, e + 3, 32'h20000, 1'b1);

    // Back-to-back single-beat groups
    clr();
    for (int n = 1; n <= 4; n++) begin
      s4_in = p4(n, 0, 0, 0);
      s4_k  = p4(1, 0, 0, 0);
      beat(1'b1, 1'b1, e);
      if (n == 1) e0 = e;
    end
    idle(6);
    chk("b2b_pulses", q4.size(), 32'd4);
    for (int n = 0; n < 4; n++) begin
      chk_ev($sformatf("b2b%0d", n), q4, n, e0 + 3 + n, 32'(n + 1), 1'b0);
    end
    chk("hold_out", s4_out, 32'd4);
    chk("hold_out_valid", 32'(s4_ov), 32'd0);

    // Size 9: only the odd last lane active, then all lanes
    clr();
    s9_in = '0;
    s9_k  = '0;
    s9_in[71:64] = 8'd3;
    s9_k[71:64]  = 8'hFC;
    beat(1'b1, 1'b1, e0);
    s9_in = {9{8'h01}};
    s9_k  = {9{8'h01}};
    beat(1'b1, 1'b1, e);
    idle(8);
    chk("s9_pulses", q9.size(), 32'd2);
    chk_ev("s9_lane8", q9, 0, e0 + 5, 32'(-12), 1'b0);
    chk_ev("s9_all", q9, 1, e + 5, 32'd9, 1'b0);

    // Size 1 unsigned: saturation at 16 bits, then a clean group
    clr();
    u1_in = 8'hFF;
    u1_k  = 8'hFF;
    beat(1'b1, 1'b0, e);
    beat(1'b0, 1'b1, e);
    u1_in = 8'd3;
    u1_k  = 8'd4;
    beat(1'b1, 1'b1, e0);
    idle(4);
    chk("u1_pulses", q1.size(), 32'd2);
    chk_ev("u1_sat", q1, 0, e + 1, 32'hFFFF, 1'b1);
    chk_ev("u1_clean", q1, 1, e0 + 1, 32'd12, 1'b0);

    // Reset with two beats in flight
    s4_in = p4(1, 1, 1, 1);
    s4_k  = p4(2, 2, 2, 2);
    beat(1'b1, 1'b0, e);
    beat(1'b0, 1'b1, e);
    rst_n = 1'b0;
    step();
    chk("mid_rst_out_valid", 32'(s4_ov), 32'd0);
    chk("mid_rst_out", s4_out, 32'd0);
    chk("mid_rst_overflow", 32'(s4_ovf), 32'd0);
    chk("mid_rst_a18_out", 32'(a18_out), 32'd0);
    rst_n = 1'b1;
    clr();
    idle(8);
    chk("mid_rst_no_pulse", q4.size(), 32'd0);
    s4_in = p4(1, 1, 1, 1);
    s4_k  = p4(1, 2, 3, 1);
    beat(1'b1, 1'b1, e);
    idle(6);
    chk("post_rst_pulses", q4.size(), 32'd1);
    chk_ev("post_rst", q4, 0, e + 3, 32'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
